// File: rtl/rcu_mdiv_rst_seq_if.sv
// Bus bundle for the PLL-lock reset sequencer and per-channel clock dividers.
// Divider updates use valid/ready: a word transfers on a clock edge where both div_valid_i[k] and div_ready_o[k] are high; valid while ready is low is ignored.
interface rcu_mdiv_rst_seq_if #(
    parameter int CH_NUM    = 4,
    parameter int DIV_WIDTH = 8,
    parameter int DLY_WIDTH = 4
);
    logic                          lock_i;
    logic [DLY_WIDTH-1:0]          rst_dly_i;
    logic [CH_NUM-1:0]             ch_en_i;
    logic [CH_NUM*DIV_WIDTH-1:0]   div_i;
    logic [CH_NUM-1:0]             div_valid_i;
    logic [CH_NUM-1:0]             div_ready_o;
    logic [CH_NUM-1:0]             div_done_o;
    logic [CH_NUM-1:0]             clk_trg_o;
    logic [CH_NUM-1:0]             clk_div_o;
    logic [CH_NUM-1:0]             rst_n_o;
    logic                          seq_busy_o;
    logic [1:0]                    seq_state_o;

    modport slave (
        input  lock_i, rst_dly_i, ch_en_i, div_i, div_valid_i,
        output div_ready_o, div_done_o, clk_trg_o, clk_div_o, rst_n_o, seq_busy_o, seq_state_o
    );

    modport master (
        output lock_i, rst_dly_i, ch_en_i, div_i, div_valid_i,
        input  div_ready_o, div_done_o, clk_trg_o, clk_div_o, rst_n_o, seq_busy_o, seq_state_o
    );
endinterface

// File: rtl/rcu_mdiv_rst_seq.sv
// Staggered per-channel reset release after PLL lock, plus per-channel
// programmable clock dividers whose value changes only at a period boundary.
module rcu_mdiv_rst_seq #(
    parameter int CH_NUM    = 4,
    parameter int DIV_WIDTH = 8,
    parameter int DIV_RST   = 3,
    parameter int DLY_WIDTH = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    rcu_mdiv_rst_seq_if.slave   bus
);
    localparam int IDX_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DLY  = 2'd1,
        S_REL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 state;
    logic [IDX_W-1:0]       idx;
    logic [DLY_WIDTH-1:0]   dcnt;
    logic [CH_NUM-1:0]      rst_n;
    logic                   busy;

    // Lock loss overrides everything, including a release due this cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_IDLE;
            idx   <= '0;
            dcnt  <= '0;
            rst_n <= '0;
            busy  <= 1'b1;
        end else if (!bus.lock_i) begin
            state <= S_IDLE;
            idx   <= '0;
            dcnt  <= '0;
            rst_n <= '0;
            busy  <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    state <= S_DLY;
                    idx   <= '0;
                    dcnt  <= '0;
                end
                S_DLY: begin
                    if (dcnt == bus.rst_dly_i) state <= S_REL;
                    else                       dcnt  <= dcnt + DLY_WIDTH'(1);
                end
                S_REL: begin
                    rst_n[idx] <= 1'b1;
                    if (idx == IDX_W'(CH_NUM - 1)) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                    end else begin
                        idx   <= idx + IDX_W'(1);
                        dcnt  <= '0;
                        state <= S_DLY;
                    end
                end
                default: state <= S_DONE;
            endcase
        end
    end

    logic [CH_NUM-1:0] pend_v;
    logic [CH_NUM-1:0] done_v;
    logic [CH_NUM-1:0] trg_v;
    logic [CH_NUM-1:0] lvl_v;

    for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
        logic [DIV_WIDTH-1:0] cnt;
        logic [DIV_WIDTH-1:0] div_q;
        logic [DIV_WIDTH-1:0] pend_val;
        logic                 pend;
        logic                 done;
        logic                 active;
        logic                 term;

        assign active = bus.ch_en_i[k] & rst_n[k];
        assign term   = (cnt == div_q);

        // Accept and load are exclusive (accept needs !pend), so a word taken
        // at terminal count waits for the following terminal count.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                cnt      <= '0;
                div_q    <= DIV_WIDTH'(DIV_RST);
                pend_val <= '0;
                pend     <= 1'b0;
                done     <= 1'b0;
            end else begin
                done <= 1'b0;
                if (bus.div_valid_i[k] && !pend) begin
                    pend     <= 1'b1;
                    pend_val <= bus.div_i[k*DIV_WIDTH +: DIV_WIDTH];
                end
                if (pend && (!active || term)) begin
                    div_q <= pend_val;
                    cnt   <= '0;
                    pend  <= 1'b0;
                    done  <= 1'b1;
                end else if (active) begin
                    cnt <= term ? '0 : cnt + DIV_WIDTH'(1);
                end else begin
                    cnt <= '0;
                end
            end
        end

        assign pend_v[k] = pend;
        assign done_v[k] = done;
        assign trg_v[k]  = active & term;
        assign lvl_v[k]  = active & (cnt <= (div_q >> 1));
    end

    assign bus.div_ready_o = ~pend_v;
    assign bus.div_done_o  = done_v;
    assign bus.clk_trg_o   = trg_v;
    assign bus.clk_div_o   = lvl_v;
    assign bus.rst_n_o     = rst_n;
    assign bus.seq_busy_o  = busy;
    assign bus.seq_state_o = state;
endmodule
